// File: rtl/accum_alu_stack.sv
// -----------------------------------------------------------------------------
// accum_alu_stack
//   Parametrised accumulator with in-place ALU operations, status flags and a
//   DEPTH-entry save/restore stack. Successor to the 8-bit load-only
//   accumulator; sits between the operand bus and the instruction decoder.
//
// Parameters
//   WIDTH  accumulator / operand width in bits (>= 4)
//   DEPTH  number of save-stack entries (>= 2, power of two)
//
// Ports
//   clk1       in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   ena        in   qualifies op; low forces HOLD
//   op[2:0]    in   000 HOLD, 001 LOAD, 010 ADD, 011 SUB,
//                   100 AND, 101 OR, 110 XOR, 111 SHL
//   data       in   operand
//   push       in   save pre-edge accum onto the stack
//   pop        in   restore top of stack into accum (overrides op)
//   accum      out  accumulator register
//   valid      out  accum has been written since reset
//   zero       out  accum == 0 after last flag-updating write
//   neg        out  accum MSB after last flag-updating write
//   carry      out  carry / borrow / shift-out of last arithmetic op
//   stk_full   out  stack holds DEPTH entries
//   stk_empty  out  stack holds no entries
//   stk_err    out  one-cycle pulse on an illegal stack request
//
// Build option
//   ACCUM_SAT_EN  when defined, ADD saturates to all-ones and SUB to zero;
//                 carry still reports that saturation occurred.
// -----------------------------------------------------------------------------
module accum_alu_stack #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk1,
   input  logic             rst,
   input  logic             ena,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] data,
   input  logic             push,
   input  logic             pop,
   output logic [WIDTH-1:0] accum,
   output logic             valid,
   output logic             zero,
   output logic             neg,
   output logic             carry,
   output logic             stk_full,
   output logic             stk_empty,
   output logic             stk_err
);

   // Pointer spans 0..DEPTH inclusive so full and empty never alias.
   localparam int unsigned PW = $clog2(DEPTH) + 1;
   localparam int unsigned IW = PW - 1;

   typedef enum logic [2:0] {
      OP_HOLD = 3'b000,
      OP_LOAD = 3'b001,
      OP_ADD  = 3'b010,
      OP_SUB  = 3'b011,
      OP_AND  = 3'b100,
      OP_OR   = 3'b101,
      OP_XOR  = 3'b110,
      OP_SHL  = 3'b111
   } op_t;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    sp;

   op_t              op_e;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_wr;

   logic             push_ok;
   logic             pop_ok;
   logic             req_err;
   logic [IW-1:0]    wr_idx;
   logic [IW-1:0]    rd_idx;

   logic [WIDTH-1:0] accum_n;
   logic             carry_n;
   logic             zero_n;
   logic             neg_n;
   logic             valid_n;
   logic             wr_any;
   logic [PW-1:0]    sp_n;

   // ALU: result and carry for the qualified op.
   always_comb begin
      op_e    = ena ? op_t'(op) : OP_HOLD;
      sum     = {1'b0, accum} + {1'b0, data};
      diff    = {1'b0, accum} - {1'b0, data};
      alu_res = accum;
      alu_c   = carry;
      alu_wr  = 1'b0;
      case (op_e)
         OP_HOLD: begin
            alu_res = accum;
         end
         OP_LOAD: begin
            alu_res = data;
            alu_c   = 1'b0;
            alu_wr  = 1'b1;
         end
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_wr  = 1'b1;
`ifdef ACCUM_SAT_EN
            if (sum[WIDTH]) alu_res = '1;
`endif
         end
         OP_SUB: begin
            // Bit WIDTH of the extended difference is the unsigned borrow.
            alu_res = diff[WIDTH-1:0];
            alu_c   = diff[WIDTH];
            alu_wr  = 1'b1;
`ifdef ACCUM_SAT_EN
            if (diff[WIDTH]) alu_res = '0;
`endif
         end
         OP_AND: begin
            alu_res = accum & data;
            alu_c   = 1'b0;
            alu_wr  = 1'b1;
         end
         OP_OR: begin
            alu_res = accum | data;
            alu_c   = 1'b0;
            alu_wr  = 1'b1;
         end
         OP_XOR: begin
            alu_res = accum ^ data;
            alu_c   = 1'b0;
            alu_wr  = 1'b1;
         end
         OP_SHL: begin
            alu_res = {accum[WIDTH-2:0], 1'b0};
            alu_c   = accum[WIDTH-1];
            alu_wr  = 1'b1;
         end
      endcase
   end

   // Stack request arbitration. push together with pop is always illegal;
   // an illegal request never blocks the same-cycle ALU op.
   always_comb begin
      push_ok = push & ~pop & ~stk_full;
      pop_ok  = pop & ~push & ~stk_empty;
      req_err = (push & pop) | (push & ~pop & stk_full) | (pop & ~push & stk_empty);
      wr_idx  = IW'(sp);
      rd_idx  = IW'(sp - PW'(1));
   end

   // Next-state selection: an accepted pop replaces the op result.
   always_comb begin
      accum_n = accum;
      carry_n = carry;
      zero_n  = zero;
      neg_n   = neg;
      valid_n = valid;
      wr_any  = 1'b0;
      sp_n    = sp;

      if (pop_ok) begin
         accum_n = mem[rd_idx];
         carry_n = 1'b0;
         wr_any  = 1'b1;
      end else if (alu_wr) begin
         accum_n = alu_res;
         carry_n = alu_c;
         wr_any  = 1'b1;
      end

      if (wr_any) begin
         zero_n  = (accum_n == '0);
         neg_n   = accum_n[WIDTH-1];
         valid_n = 1'b1;
      end

      if (push_ok)     sp_n = sp + PW'(1);
      else if (pop_ok) sp_n = sp - PW'(1);
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         accum     <= '0;
         valid     <= 1'b0;
         zero      <= 1'b1;
         neg       <= 1'b0;
         carry     <= 1'b0;
         sp        <= '0;
         stk_full  <= 1'b0;
         stk_empty <= 1'b1;
         stk_err   <= 1'b0;
      end else begin
         accum     <= accum_n;
         valid     <= valid_n;
         zero      <= zero_n;
         neg       <= neg_n;
         carry     <= carry_n;
         sp        <= sp_n;
         stk_full  <= (sp_n == PW'(DEPTH));
         stk_empty <= (sp_n == '0);
         stk_err   <= req_err;
      end
   end

   // Stack storage is not reset; only the pointer is.
   always_ff @(posedge clk1) begin
      if (push_ok) mem[wr_idx] <= accum;
   end

endmodule

// File: tb/tb_accum_alu_stack.sv
module tb_accum_alu_stack;

   localparam int unsigned W = 8;

   typedef struct packed {
      logic [W-1:0] accum;
      logic         valid;
      logic         zero;
      logic         neg;
      logic         carry;
      logic         full;
      logic         empty;
      logic         err;
   } out_t;

   typedef struct {
      logic         rst;
      logic         ena;
      logic [2:0]   op;
      logic [W-1:0] data;
      logic         push;
      logic         pop;
      out_t         exp;
   } vec_t;

   logic         clk1 = 1'b0;
   logic         rst  = 1'b0;
   logic         ena  = 1'b0;
   logic [2:0]   op   = 3'b000;
   logic [W-1:0] data = '0;
   logic         push = 1'b0;
   logic         pop  = 1'b0;
   logic [W-1:0] accum;
   logic         valid, zero, neg, carry, stk_full, stk_empty, stk_err;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   vec_t vecs[$];
   out_t sb[$];

   accum_alu_stack #(.WIDTH(W), .DEPTH(4)) dut (
      .clk1(clk1), .rst(rst), .ena(ena), .op(op), .data(data),
      .push(push), .pop(pop), .accum(accum), .valid(valid), .zero(zero),
      .neg(neg), .carry(carry), .stk_full(stk_full), .stk_empty(stk_empty),
      .stk_err(stk_err)
   );

   always #5 clk1 = ~clk1;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish (got running, need done)");
      $fatal(1, "timeout");
   end

   function automatic out_t mk(input logic [W-1:0] a, input logic v, z, n, c, f, e, er);
      out_t o;
      o = '{accum: a, valid: v, zero: z, neg: n, carry: c, full: f, empty: e, err: er};
      return o;
   endfunction

   function automatic vec_t vv(input logic r, en, input logic [2:0] o, input logic [W-1:0] d,
                               input logic pu, po, input out_t ex);
      vec_t t;
      t = '{rst: r, ena: en, op: o, data: d, push: pu, pop: po, exp: ex};
      return t;
   endfunction

   // Drive one cycle of stimulus, queue its expectation, compare after the edge.
   task automatic apply(input string name, input vec_t t);
      out_t got, want;
      @(negedge clk1);
      rst = t.rst; ena = t.ena; op = t.op; data = t.data; push = t.push; pop = t.pop;
      sb.push_back(t.exp);
      @(posedge clk1);
      #1;
      got  = '{accum: accum, valid: valid, zero: zero, neg: neg, carry: carry,
               full: stk_full, empty: stk_empty, err: stk_err};
      want = sb.pop_front();
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got accum=%h v%b z%b n%b c%b full%b empty%b err%b, need accum=%h v%b z%b n%b c%b full%b empty%b err%b",
                  name, got.accum, got.valid, got.zero, got.neg, got.carry, got.full, got.empty, got.err,
                  want.accum, want.valid, want.zero, want.neg, want.carry, want.full, want.empty, want.err);
      end
   endtask

   localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, ADD = 3'd2, SUB = 3'd3,
                          AND_ = 3'd4, OR_ = 3'd5, XOR_ = 3'd6, SHL = 3'd7;

   initial begin
      logic [W-1:0] model[$];
      logic [W-1:0] val;
      logic [W-1:0] top;

      //               rst en op    data   pu po   accum v  z  n  c  F  E  err
      vecs.push_back(vv(1, 0, HOLD, 8'h00, 0, 0, mk(8'h00, 0, 1, 0, 0, 0, 1, 0)));
      vecs.push_back(vv(1, 1, LOAD, 8'h77, 0, 0, mk(8'h00, 0, 1, 0, 0, 0, 1, 0)));
      vecs.push_back(vv(0, 1, LOAD, 8'h5A, 0, 0, mk(8'h5A, 1, 0, 0, 0, 0, 1, 0)));
      vecs.push_back(vv(0, 0, LOAD, 8'hFF, 0, 0, mk(8'h5A, 1, 0, 0, 0, 0, 1, 0)));
      vecs.push_back(vv(0, 1, LOAD, 8'hF0, 0, 0, mk(8'hF0, 1, 0, 1, 0, 0, 1, 0)));
`ifdef ACCUM_SAT_EN
      vecs.push_back(vv(0, 1, ADD,  8'h20, 0, 0, mk(8'hFF, 1, 0, 1, 1, 0, 1, 0)));
      vecs.push_back(vv(0, 1, LOAD, 8'h10, 0, 0, mk(8'h10, 1, 0, 0, 0, 0, 1, 0)));
      vecs.push_back(vv(0, 1, SUB,  8'h11, 0, 0, mk(8'h00, 1, 1, 0, 1, 0, 1, 0)));
      vecs.push_back(vv(0, 1, HOLD, 8'h42, 0, 0, mk(8'h00, 1, 1, 0, 1, 0, 1, 0)));
`else
      vecs.push_back(vv(0, 1, ADD,  8'h20, 0, 0, mk(8'h10, 1, 0, 0, 1, 0, 1, 0)));
      vecs.push_back(vv(0, 1, LOAD, 8'h10, 0, 0, mk(8'h10, 1, 0, 0, 0, 0, 1, 0)));
      vecs.push_back(vv(0, 1, SUB,  8'h11, 0, 0, mk(8'hFF, 1, 0, 1, 1, 0, 1, 0)));
      vecs.push_back(vv(0, 1, HOLD, 8'h42, 0, 0, mk(8'hFF, 1, 0, 1, 1, 0, 1, 0)));
`endif
      vecs.push_back(vv(0, 1, LOAD, 8'h50, 0, 0, mk(8'h50, 1, 0, 0, 0, 0, 1, 0)));
      vecs.push_back(vv(0, 1, SUB,  8'h20, 0, 0, mk(8'h30, 1, 0, 0, 0, 0, 1, 0)));
      vecs.push_back(vv(0, 1, ADD,  8'h10, 0, 0, mk(8'h40, 1, 0, 0, 0, 0, 1, 0)));
      // push with a same-cycle op, then pop overriding LOAD
      vecs.push_back(vv(0, 1, LOAD, 8'h33, 0, 0, mk(8'h33, 1, 0, 0, 0, 0, 1, 0)));
      vecs.push_back(vv(0, 1, ADD,  8'h01, 1, 0, mk(8'h34, 1, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(vv(0, 1, OR_,  8'h80, 0, 0, mk(8'hB4, 1, 0, 1, 0, 0, 0, 0)));
      vecs.push_back(vv(0, 1, SHL,  8'h00, 0, 0, mk(8'h68, 1, 0, 0, 1, 0, 0, 0)));
      vecs.push_back(vv(0, 1, LOAD, 8'h99, 0, 1, mk(8'h33, 1, 0, 0, 0, 0, 1, 0)));
      vecs.push_back(vv(0, 1, AND_, 8'h0F, 0, 0, mk(8'h03, 1, 0, 0, 0, 0, 1, 0)));
      // fill, overflow, drain, underflow
      vecs.push_back(vv(0, 1, LOAD, 8'h01, 0, 0, mk(8'h01, 1, 0, 0, 0, 0, 1, 0)));
      vecs.push_back(vv(0, 1, LOAD, 8'h02, 1, 0, mk(8'h02, 1, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(vv(0, 1, LOAD, 8'h03, 1, 0, mk(8'h03, 1, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(vv(0, 1, LOAD, 8'h04, 1, 0, mk(8'h04, 1, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(vv(0, 1, LOAD, 8'h05, 1, 0, mk(8'h05, 1, 0, 0, 0, 1, 0, 0)));
      vecs.push_back(vv(0, 1, XOR_, 8'h0F, 1, 0, mk(8'h0A, 1, 0, 0, 0, 1, 0, 1)));
      vecs.push_back(vv(0, 0, HOLD, 8'h00, 0, 0, mk(8'h0A, 1, 0, 0, 0, 1, 0, 0)));
      vecs.push_back(vv(0, 0, HOLD, 8'h00, 0, 1, mk(8'h04, 1, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(vv(0, 0, HOLD, 8'h00, 0, 1, mk(8'h03, 1, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(vv(0, 0, HOLD, 8'h00, 0, 1, mk(8'h02, 1, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(vv(0, 0, HOLD, 8'h00, 0, 1, mk(8'h01, 1, 0, 0, 0, 0, 1, 0)));
      vecs.push_back(vv(0, 1, HOLD, 8'h00, 0, 1, mk(8'h01, 1, 0, 0, 0, 0, 1, 1)));
      vecs.push_back(vv(0, 0, HOLD, 8'h00, 0, 0, mk(8'h01, 1, 0, 0, 0, 0, 1, 0)));
      // simultaneous push+pop: both ignored, op still runs
      vecs.push_back(vv(0, 1, LOAD, 8'h0F, 0, 0, mk(8'h0F, 1, 0, 0, 0, 0, 1, 0)));
      vecs.push_back(vv(0, 1, XOR_, 8'hFF, 1, 1, mk(8'hF0, 1, 0, 1, 0, 0, 1, 1)));
      vecs.push_back(vv(0, 0, HOLD, 8'h00, 1, 0, mk(8'hF0, 1, 0, 1, 0, 0, 0, 0)));
      vecs.push_back(vv(0, 1, XOR_, 8'hFF, 1, 1, mk(8'h0F, 1, 0, 0, 0, 0, 0, 1)));
      // reset mid-sequence with pop asserted
      vecs.push_back(vv(0, 1, LOAD, 8'h80, 1, 0, mk(8'h80, 1, 0, 1, 0, 0, 0, 0)));
      vecs.push_back(vv(1, 1, LOAD, 8'h11, 0, 1, mk(8'h00, 0, 1, 0, 0, 0, 1, 0)));
      vecs.push_back(vv(0, 0, HOLD, 8'h00, 0, 1, mk(8'h00, 0, 1, 0, 0, 0, 1, 1)));
      vecs.push_back(vv(0, 0, HOLD, 8'h00, 0, 0, mk(8'h00, 0, 1, 0, 0, 0, 1, 0)));

      for (int i = 0; i < vecs.size(); i++) begin
         apply($sformatf("vec%0d", i), vecs[i]);
      end

      // Hand sequence: random values pushed then popped, checked against a LIFO model.
      for (int i = 0; i < 4; i++) begin
         val = W'($urandom_range(1, 255));
         apply($sformatf("lifo_load%0d", i),
               vv(0, 1, LOAD, val, 0, 0, mk(val, 1, 0, val[W-1], 0, model.size() == 4, model.size() == 0, 0)));
         model.push_back(val);
         apply($sformatf("lifo_push%0d", i),
               vv(0, 0, HOLD, 8'h00, 1, 0, mk(val, 1, 0, val[W-1], 0, model.size() == 4, 0, 0)));
      end
      for (int i = 0; i < 4; i++) begin
         top = model.pop_back();
         apply($sformatf("lifo_pop%0d", i),
               vv(0, 1, SHL, 8'h00, 0, 1, mk(top, 1, 0, top[W-1], 0, 0, model.size() == 0, 0)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
